// File: rtl/reg_dump_serializer_pkg.sv
// Shared debug-dump definitions: FSM encoding, default header byte, and the
// dump length rule. The memory-dump block and the host decoder use these too.
package reg_dump_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    FIN  = 2'd3
  } dump_state_t;

  localparam logic [7:0] DUMP_HEADER = 8'hA5;

  // Bytes in one dump: payload plus an optional leading header byte.
  function automatic int unsigned dump_total_bytes(input int unsigned num_regs,
                                                   input int unsigned data_width,
                                                   input bit          header_en);
    return (num_regs * data_width) / 8 + (header_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/reg_dump_serializer_if.sv
// Dump request / UART-TX handshake bundle between the host side and the serializer.
interface reg_dump_serializer_if #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                           start;
  logic [NUM_REGS*DATA_WIDTH-1:0] registers;
  logic                           tx_done;
  logic [7:0]                     tx_data;
  logic                           tx_start;
  logic                           busy;
  logic                           done;

  modport master (
    output start, registers, tx_done,
    input  tx_data, tx_start, busy, done
  );

  modport slave (
    input  start, registers, tx_done,
    output tx_data, tx_start, busy, done
  );

endinterface

// File: rtl/reg_dump_serializer.sv
// Snapshots the flat register-file bus on start and streams it byte by byte
// (optional header first, then register 0 MSB byte onward) to a UART transmitter.
module reg_dump_serializer
  import reg_dump_serializer_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [7:0]  HEADER_BYTE = DUMP_HEADER
) (
  input logic                  clk,
  input logic                  reset,
  reg_dump_serializer_if.slave bus
);

  localparam int unsigned SNAP_W = NUM_REGS * DATA_WIDTH;
  localparam int unsigned TOTAL  = dump_total_bytes(NUM_REGS, DATA_WIDTH, HEADER_EN);
  localparam int unsigned CNT_W  = $clog2(TOTAL + 1);

  dump_state_t       state, state_n;
  logic [SNAP_W-1:0] snap, snap_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [7:0]        byte_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      snap         <= '0;
      cnt          <= '0;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state        <= state_n;
      snap         <= snap_n;
      cnt          <= cnt_n;
      // Outputs are decoded from the next state so they line up with the state they describe.
      bus.tx_start <= (state_n == SEND);
      bus.busy     <= (state_n != IDLE);
      bus.done     <= (state_n == FIN);
      if (state_n == SEND) begin
        bus.tx_data <= byte_n;
      end
    end
  end

  always_comb begin
    state_n = state;
    snap_n  = snap;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          snap_n  = bus.registers;
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: state_n = WAIT;
      WAIT: begin
        if (bus.tx_done) begin
          cnt_n = cnt + 1'b1;
          // The header is not part of the snapshot, so it consumes no shift.
          if (!(HEADER_EN && (cnt == '0))) begin
            snap_n = snap << 8;
          end
          state_n = (cnt_n == CNT_W'(TOTAL)) ? FIN : SEND;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    byte_n = (HEADER_EN && (cnt_n == '0)) ? HEADER_BYTE : snap_n[SNAP_W-1 -: 8];
  end

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Runs a header-enabled and a header-less serializer side by side against a
// UART responder and a byte-list reference model.
module tb_reg_dump_serializer;

  localparam int unsigned NREG = 32;
  localparam int unsigned GOTN = 2048;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              start     = 1'b0;
  logic [NREG*32-1:0] regs_flat = '0;
  logic [31:0]       r     [NREG];
  logic [31:0]       exp_r [NREG];

  always #5 clk = ~clk;

  reg_dump_serializer_if #(.NUM_REGS(NREG), .DATA_WIDTH(32)) bus [2] ();

  reg_dump_serializer #(
    .NUM_REGS(NREG), .DATA_WIDTH(32), .HEADER_EN(1'b1), .HEADER_BYTE(8'hA5)
  ) u_dut_hdr (
    .clk(clk), .reset(reset), .bus(bus[0])
  );

  reg_dump_serializer #(
    .NUM_REGS(NREG), .DATA_WIDTH(32), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5)
  ) u_dut_raw (
    .clk(clk), .reset(reset), .bus(bus[1])
  );

  logic [7:0] o_data  [2];
  logic       o_start [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  logic       tx_done_v [2] = '{1'b0, 1'b0};

  for (genvar k = 0; k < 2; k++) begin : g_bus
    assign bus[k].start     = start;
    assign bus[k].registers = regs_flat;
    assign bus[k].tx_done   = tx_done_v[k];
    assign o_data[k]        = bus[k].tx_data;
    assign o_start[k]       = bus[k].tx_start;
    assign o_busy[k]        = bus[k].busy;
    assign o_done[k]        = bus[k].done;
  end

  // UART responder and protocol monitor, sampled mid-cycle.
  int unsigned pulse_cnt [2];
  int unsigned done_cnt  [2];
  int unsigned inflight  [2];
  logic [7:0]  last_data [2];
  logic [7:0]  got_b     [2][GOTN];
  int unsigned busy_err, overlap_err, hold_err;
  int unsigned lat_fixed = 10;
  bit          spur      = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      tx_done_v[k] = 1'b0;
      if (reset) begin
        inflight[k] = 0;
      end else begin
        if (o_start[k] && inflight[k] != 0) overlap_err++;
        if ((inflight[k] != 0 || o_start[k]) && !o_busy[k]) busy_err++;
        if (!o_start[k] && o_data[k] !== last_data[k]) hold_err++;
        if (inflight[k] != 0) begin
          inflight[k]--;
          if (inflight[k] == 0) tx_done_v[k] = 1'b1;
        end
        if (o_start[k]) begin
          got_b[k][pulse_cnt[k] % GOTN] = o_data[k];
          pulse_cnt[k]++;
          inflight[k] = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 12);
          if (spur) tx_done_v[k] = 1'b1;
        end else if (spur && !o_busy[k] && $urandom_range(0, 3) == 0) begin
          tx_done_v[k] = 1'b1;
        end
        if (o_done[k]) done_cnt[k]++;
      end
      last_data[k] = o_data[k];
    end
  end

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned base_p [2];
  int unsigned base_d [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_regs();
    for (int i = 0; i < NREG; i++) regs_flat[(NREG-1-i)*32 +: 32] = r[i];
  endtask

  task automatic rand_regs();
    for (int i = 0; i < NREG; i++) r[i] = $urandom;
    pack_regs();
  endtask

  // Reference: byte j of a dump as seen by DUT k (k=0 carries the header).
  function automatic logic [7:0] exp_byte(input int k, input int unsigned j);
    int unsigned idx;
    if (k == 0 && j == 0) return 8'hA5;
    idx = (k == 0) ? j - 1 : j;
    return exp_r[idx / 4][8*(3 - idx % 4) +: 8];
  endfunction

  task automatic check_quiet(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_k%0d_tx_data", tag, k), 32'(o_data[k]), 32'd0);
      check($sformatf("%s_k%0d_tx_start", tag, k), 32'(o_start[k]), 32'd0);
      check($sformatf("%s_k%0d_busy", tag, k), 32'(o_busy[k]), 32'd0);
      check($sformatf("%s_k%0d_done", tag, k), 32'(o_done[k]), 32'd0);
    end
  endtask

  task automatic begin_dump(input string tag);
    for (int k = 0; k < 2; k++) begin
      base_p[k] = pulse_cnt[k];
      base_d[k] = done_cnt[k];
    end
    for (int i = 0; i < NREG; i++) exp_r[i] = r[i];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_k%0d_busy_at_capture", tag, k), 32'(o_busy[k]), 32'd1);
      check($sformatf("%s_k%0d_first_tx_start", tag, k), 32'(o_start[k]), 32'd1);
      check($sformatf("%s_k%0d_first_byte", tag, k), 32'(o_data[k]), 32'(exp_byte(k, 0)));
    end
  endtask

  task automatic wait_done(input string tag);
    int unsigned cyc = 0;
    while ((done_cnt[0] == base_d[0] || done_cnt[1] == base_d[1]) && cyc < 6000) begin
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(cyc < 6000), 32'd1);
  endtask

  task automatic wait_pulses(input string tag, input int unsigned n);
    int unsigned cyc = 0;
    while (pulse_cnt[0] - base_p[0] < n && cyc < 4000) begin
      tick();
      cyc++;
    end
    check({tag, "_pulses_reached"}, 32'(cyc < 4000), 32'd1);
  endtask

  task automatic check_dump(input string tag);
    int unsigned n;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 129 : 128;
      check($sformatf("%s_k%0d_byte_count", tag, k), pulse_cnt[k] - base_p[k], n);
      check($sformatf("%s_k%0d_done_count", tag, k), done_cnt[k] - base_d[k], 32'd1);
      for (int unsigned j = 0; j < n; j++) begin
        check($sformatf("%s_k%0d_b%0d", tag, k, j),
              32'(got_b[k][(base_p[k] + j) % GOTN]), 32'(exp_byte(k, j)));
      end
    end
    check({tag, "_protocol_errors"}, busy_err + overlap_err + hold_err, 32'd0);
  endtask

  initial begin
    int unsigned p_hold [2];

    for (int i = 0; i < NREG; i++) r[i] = '0;
    pack_regs();
    repeat (3) tick();
    check_quiet("reset");
    #2 reset = 1'b0;
    repeat (2) tick();
    check_quiet("idle");

    // Ramp pattern, fixed 10-cycle UART time.
    for (int i = 0; i < NREG; i++) r[i] = 32'h0101_0101 * 32'(i);
    r[0] = 32'hDEAD_BEEF;
    r[0] = '0;
    pack_regs();
    begin_dump("ramp");
    wait_done("ramp");
    repeat (4) tick();
    check_dump("ramp");

    // Boundary registers plus a register-file write right after capture.
    lat_fixed = 0;
    rand_regs();
    r[0]  = 32'hDEAD_BEEF;
    r[31] = 32'h1234_5678;
    pack_regs();
    begin_dump("snap");
    r[5] = ~r[5];
    pack_regs();
    wait_done("snap");
    repeat (4) tick();
    check_dump("snap");

    // Second start mid-dump and spurious tx_done in SEND/IDLE.
    spur = 1'b1;
    rand_regs();
    begin_dump("restart");
    wait_pulses("restart", 40);
    rand_regs();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("restart");
    repeat (6) tick();
    spur = 1'b0;
    check_dump("restart");

    // Reset in the middle of a dump.
    rand_regs();
    begin_dump("abort");
    wait_pulses("abort", 60);
    #2 reset = 1'b1;
    #1 check_quiet("abort_reset");
    p_hold[0] = pulse_cnt[0];
    p_hold[1] = pulse_cnt[1];
    repeat (2) tick();
    #2 reset = 1'b0;
    repeat (40) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort_k%0d_no_tx_start", k), pulse_cnt[k], p_hold[k]);
      check($sformatf("abort_k%0d_no_done", k), done_cnt[k] - base_d[k], 32'd0);
    end
    rand_regs();
    begin_dump("post_reset");
    wait_done("post_reset");
    repeat (4) tick();
    check_dump("post_reset");

    // Back-to-back: second start in the cycle right after done.
    lat_fixed = 3;
    rand_regs();
    begin_dump("b2b_first");
    wait_done("b2b_first");
    check_dump("b2b_first");
    rand_regs();
    begin_dump("b2b_second");
    wait_done("b2b_second");
    repeat (4) tick();
    check_dump("b2b_second");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
